// File: rtl/drink_selector_if.sv
// Front-panel / brew-controller signal bundle for the drink selector.
// The slave modport is the selector itself; the master modport is whoever drives the panel.
interface drink_selector_if #(
   parameter int IDX_W  = 1,
   parameter int CODE_W = 3
);
   logic              sel_en;
   logic              btn_next;
   logic              btn_ok;
   logic              btn_cancel;
   logic              req_ready;
   logic              brew_done;
   logic [IDX_W-1:0]  sel_idx;
   logic [CODE_W-1:0] sel_code;
   logic              req_valid;
   logic              busy;

   modport master (
      output sel_en, btn_next, btn_ok, btn_cancel, req_ready, brew_done,
      input  sel_idx, sel_code, req_valid, busy
   );

   modport slave (
      input  sel_en, btn_next, btn_ok, btn_cancel, req_ready, brew_done,
      output sel_idx, sel_code, req_valid, busy
   );
endinterface

// File: rtl/drink_selector.sv
// Drink-choice selector: browse N_CHOICES drinks, confirm into a valid/ready request,
// then stay locked until the brew controller reports completion.
module drink_selector #(
   parameter int N_CHOICES  = 2,
   parameter int CODE_W     = 3,
   parameter int CODE_SHIFT = 2,
   parameter int TIMEOUT    = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   drink_selector_if.slave  bus
);
   localparam int IDX_W = $clog2(N_CHOICES);
   localparam int TMR_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BROWSE = 2'd1,
      ST_HOLD   = 2'd2,
      ST_LOCK   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic [TMR_W-1:0]  r_timer;
   logic [TMR_W-1:0]  w_timer_nxt;
   logic [CODE_W-1:0] r_code;
   logic              r_valid;
   logic              r_busy;

   // Code is built in 32 bits and then cut to CODE_W, so high index bits may fall off.
   function automatic logic [CODE_W-1:0] code_of(input logic [IDX_W-1:0] idx);
      logic [31:0] wide;
      wide = (32'(idx) << CODE_SHIFT) | 32'd1;
      return wide[CODE_W-1:0];
   endfunction

   // Next-state, next-index and idle-timer decode.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_timer_nxt = r_timer;
      case (r_state)
         ST_IDLE: begin
            w_idx_nxt   = '0;
            w_timer_nxt = '0;
            if (bus.sel_en) begin
               w_state_nxt = ST_BROWSE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BROWSE: begin
            if (!bus.sel_en || bus.btn_cancel) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_timer_nxt = '0;
            end else if (bus.btn_ok) begin
               w_state_nxt = ST_HOLD;
            end else if (bus.btn_next) begin
               w_timer_nxt = '0;
               if (r_idx == IDX_W'(N_CHOICES - 1)) begin
                  w_idx_nxt = '0;
               end else begin
                  w_idx_nxt = r_idx + IDX_W'(1);
               end
            end else if (r_timer >= TMR_W'(TIMEOUT - 1)) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + TMR_W'(1);
            end
         end
         ST_HOLD: begin
            // A completed handshake outranks a same-cycle cancel.
            if (r_valid && bus.req_ready) begin
               w_state_nxt = ST_LOCK;
            end else if (bus.btn_cancel) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_timer_nxt = '0;
            end else begin
               w_state_nxt = ST_HOLD;
            end
         end
         ST_LOCK: begin
            if (bus.brew_done) begin
               w_state_nxt = bus.sel_en ? ST_BROWSE : ST_IDLE;
               w_idx_nxt   = '0;
               w_timer_nxt = '0;
            end else begin
               w_state_nxt = ST_LOCK;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_timer_nxt = '0;
         end
      endcase
   end

   // State, index, timer and output registers; outputs follow the next state directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_timer <= '0;
         r_code  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_timer <= w_timer_nxt;
         r_code  <= (w_state_nxt == ST_IDLE) ? '0 : code_of(w_idx_nxt);
         r_valid <= (w_state_nxt == ST_HOLD);
         r_busy  <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_LOCK);
      end
   end

   assign bus.sel_idx   = r_idx;
   assign bus.sel_code  = r_code;
   assign bus.req_valid = r_valid;
   assign bus.busy      = r_busy;
endmodule
